// File: rtl/pipe_ctl_chain.sv
// rtl/pipe_ctl_chain.sv - parametrised control-word pipeline with stall, flush, rd scoreboard and retire counter
module pipe_ctl_chain #(
   parameter int               NUM_STAGES = 3,
   parameter int               CTL_W      = 16,
   parameter int               RD_W       = 5,
   parameter int               REGW_BIT   = 0,
   parameter int               LOAD_BIT   = 1,
   parameter logic [CTL_W-1:0] BUBBLE_CTL = '0,
   parameter int               CNT_W      = 32
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_valid,
   input  logic [CTL_W-1:0]            i_ctl,
   input  logic [RD_W-1:0]             i_rd,
   output logic                        o_in_ready,
   input  logic [NUM_STAGES-1:0]       i_stall,
   input  logic [NUM_STAGES-1:0]       i_flush,
   output logic [NUM_STAGES*CTL_W-1:0] o_stage_ctl,
   output logic [NUM_STAGES-1:0]       o_stage_valid,
   output logic [NUM_STAGES*RD_W-1:0]  o_stage_rd,
   input  logic [RD_W-1:0]             i_rs1,
   input  logic [RD_W-1:0]             i_rs2,
   output logic [NUM_STAGES-1:0]       o_rs1_busy,
   output logic [NUM_STAGES-1:0]       o_rs2_busy,
   output logic                        o_load_use,
   output logic                        o_retire,
   output logic [CNT_W-1:0]            o_retired_cnt
);

   // Reject parameter sets whose control bits fall outside the word or that have no stages
   if (NUM_STAGES < 1) begin : g_bad_stages
      $error("pipe_ctl_chain: NUM_STAGES must be >= 1");
   end
   if (REGW_BIT >= CTL_W || LOAD_BIT >= CTL_W) begin : g_bad_bits
      $error("pipe_ctl_chain: REGW_BIT and LOAD_BIT must be below CTL_W");
   end

   logic [CTL_W-1:0]      ctl_q   [NUM_STAGES];
   logic [RD_W-1:0]       rd_q    [NUM_STAGES];
   logic                  valid_q [NUM_STAGES];
   logic [NUM_STAGES-1:0] hold;
   logic                  hold_acc;
   logic [CNT_W-1:0]      cnt_q;

   // A stall freezes its own stage and everything upstream of it
   always_comb begin
      hold_acc = 1'b0;
      hold     = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         hold_acc = hold_acc | i_stall[k];
         hold[k]  = hold_acc;
      end
   end

   assign o_in_ready = !hold[0];

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // Stage 0 loads from ID; flush beats stall, an idle ID slot becomes a bubble
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               valid_q[0] <= 1'b0;
               ctl_q[0]   <= BUBBLE_CTL;
               rd_q[0]    <= '0;
            end else if (i_flush[0]) begin
               valid_q[0] <= 1'b0;
               ctl_q[0]   <= BUBBLE_CTL;
               rd_q[0]    <= '0;
            end else if (!hold[0]) begin
               if (i_valid) begin
                  valid_q[0] <= 1'b1;
                  ctl_q[0]   <= i_ctl;
                  rd_q[0]    <= i_rd;
               end else begin
                  valid_q[0] <= 1'b0;
                  ctl_q[0]   <= BUBBLE_CTL;
                  rd_q[0]    <= '0;
               end
            end
         end
      end else begin : g_next
         // Later stages copy upstream, or take a bubble when upstream is frozen and this stage drains
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               valid_q[k] <= 1'b0;
               ctl_q[k]   <= BUBBLE_CTL;
               rd_q[k]    <= '0;
            end else if (i_flush[k]) begin
               valid_q[k] <= 1'b0;
               ctl_q[k]   <= BUBBLE_CTL;
               rd_q[k]    <= '0;
            end else if (!hold[k]) begin
               if (hold[k-1]) begin
                  valid_q[k] <= 1'b0;
                  ctl_q[k]   <= BUBBLE_CTL;
                  rd_q[k]    <= '0;
               end else begin
                  valid_q[k] <= valid_q[k-1];
                  ctl_q[k]   <= ctl_q[k-1];
                  rd_q[k]    <= rd_q[k-1];
               end
            end
         end
      end
   end

   // Flatten stage contents and answer in-flight rd queries; bubbles and x0 never count as busy
   always_comb begin
      o_stage_ctl   = '0;
      o_stage_rd    = '0;
      o_stage_valid = '0;
      o_rs1_busy    = '0;
      o_rs2_busy    = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         o_stage_ctl[k*CTL_W +: CTL_W] = ctl_q[k];
         o_stage_rd[k*RD_W +: RD_W]    = rd_q[k];
         o_stage_valid[k]              = valid_q[k];
         o_rs1_busy[k] = valid_q[k] && ctl_q[k][REGW_BIT] && (rd_q[k] != '0) && (rd_q[k] == i_rs1);
         o_rs2_busy[k] = valid_q[k] && ctl_q[k][REGW_BIT] && (rd_q[k] != '0) && (rd_q[k] == i_rs2);
      end
   end

   assign o_load_use = valid_q[0] && ctl_q[0][LOAD_BIT] && (rd_q[0] != '0) &&
                       ((rd_q[0] == i_rs1) || (rd_q[0] == i_rs2));

   assign o_retire = valid_q[NUM_STAGES-1] && !hold[NUM_STAGES-1];

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else if (o_retire) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign o_retired_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctl_chain.sv
// tb/tb_pipe_ctl_chain.sv - directed self-checking bench for pipe_ctl_chain
module tb_pipe_ctl_chain;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic [15:0] i_ctl;
   logic [4:0]  i_rd;
   logic        o_in_ready;
   logic [2:0]  i_stall;
   logic [2:0]  i_flush;
   logic [47:0] o_stage_ctl;
   logic [2:0]  o_stage_valid;
   logic [14:0] o_stage_rd;
   logic [4:0]  i_rs1;
   logic [4:0]  i_rs2;
   logic [2:0]  o_rs1_busy;
   logic [2:0]  o_rs2_busy;
   logic        o_load_use;
   logic        o_retire;
   logic [31:0] o_retired_cnt;

   logic        d4_valid;
   logic        d4_in_ready;
   logic [47:0] d4_stage_ctl;
   logic [2:0]  d4_stage_valid;
   logic [14:0] d4_stage_rd;
   logic [2:0]  d4_rs1_busy;
   logic [2:0]  d4_rs2_busy;
   logic        d4_load_use;
   logic        d4_retire;
   logic [3:0]  d4_retired_cnt;

   int checks;
   int errors;

   pipe_ctl_chain dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_ctl(i_ctl), .i_rd(i_rd),
      .o_in_ready(o_in_ready), .i_stall(i_stall), .i_flush(i_flush),
      .o_stage_ctl(o_stage_ctl), .o_stage_valid(o_stage_valid), .o_stage_rd(o_stage_rd),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
      .o_load_use(o_load_use), .o_retire(o_retire), .o_retired_cnt(o_retired_cnt)
   );

   pipe_ctl_chain #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(d4_valid), .i_ctl(16'h0001), .i_rd(5'd1),
      .o_in_ready(d4_in_ready), .i_stall(3'b000), .i_flush(3'b000),
      .o_stage_ctl(d4_stage_ctl), .o_stage_valid(d4_stage_valid), .o_stage_rd(d4_stage_rd),
      .i_rs1(5'd0), .i_rs2(5'd0), .o_rs1_busy(d4_rs1_busy), .o_rs2_busy(d4_rs2_busy),
      .o_load_use(d4_load_use), .o_retire(d4_retire), .o_retired_cnt(d4_retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] s_ctl(input int k);
      return o_stage_ctl[k*16 +: 16];
   endfunction

   function automatic logic [4:0] s_rd(input int k);
      return o_stage_rd[k*5 +: 5];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_ctl = '0; i_rd = '0; i_stall = '0; i_flush = '0;
      i_rs1 = '0; i_rs2 = '0; d4_valid = 1'b0;
      #12;
      checks++; if (o_stage_valid !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", o_stage_valid); end
      checks++; if (o_stage_ctl !== 48'h0) begin errors++; $display("FAIL reset_ctl got %h exp 0", o_stage_ctl); end
      checks++; if (o_stage_rd !== 15'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", o_stage_rd); end
      checks++; if (o_retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_retired_cnt); end
      checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      int nret;
      nret = 0;
      for (int c = 1; c <= 7; c++) begin
         i_valid = (c <= 4);
         i_ctl   = 16'(c);
         i_rd    = 5'(c + 8);
         tick();
         if (c >= 3 && c <= 6) begin
            checks++; if (o_stage_valid[2] !== 1'b1 || s_ctl(2) !== 16'(c - 2) || s_rd(2) !== 5'(c + 6)) begin
               errors++; $display("FAIL stream_s2 c=%0d got v=%b ctl=%h rd=%0d exp v=1 ctl=%h rd=%0d",
                                  c, o_stage_valid[2], s_ctl(2), s_rd(2), 16'(c - 2), c + 6);
            end
         end else begin
            checks++; if (o_stage_valid[2] !== 1'b0) begin errors++; $display("FAIL stream_s2_empty c=%0d got %b exp 0", c, o_stage_valid[2]); end
         end
         checks++; if (o_retire !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL stream_retire c=%0d got %b", c, o_retire); end
         if (o_retire === 1'b1) nret++;
      end
      checks++; if (nret != 4) begin errors++; $display("FAIL stream_retire_cycles got %0d exp 4", nret); end
      checks++; if (o_retired_cnt !== 32'd4) begin errors++; $display("FAIL stream_cnt got %0d exp 4", o_retired_cnt); end
   endtask

   task automatic test_stall();
      for (int w = 0; w < 3; w++) begin
         i_valid = 1'b1; i_ctl = 16'(16'h10 + w); i_rd = 5'(w + 1);
         tick();
      end
      i_ctl = 16'h13; i_rd = 5'd4; i_stall = 3'b010;
      #1;
      checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", o_in_ready); end
      checks++; if (o_retire !== 1'b1) begin errors++; $display("FAIL stall_retire got %b exp 1", o_retire); end
      tick();
      checks++; if (o_stage_valid !== 3'b011 || s_ctl(0) !== 16'h12 || s_ctl(1) !== 16'h11 || s_ctl(2) !== 16'h0) begin
         errors++; $display("FAIL stall_hold got v=%b ctl=%h exp v=011 ctl=000000110012", o_stage_valid, o_stage_ctl);
      end
      i_stall = 3'b000;
      #1;
      checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", o_in_ready); end
      tick();
      checks++; if (o_stage_valid !== 3'b111 || s_ctl(0) !== 16'h13 || s_ctl(1) !== 16'h12 || s_ctl(2) !== 16'h11) begin
         errors++; $display("FAIL stall_resume got v=%b ctl=%h exp v=111 ctl=001100120013", o_stage_valid, o_stage_ctl);
      end
      i_valid = 1'b0;
      tick();
      checks++; if (o_stage_valid[2] !== 1'b1 || s_ctl(2) !== 16'h12) begin errors++; $display("FAIL stall_drain1 got v=%b ctl=%h exp 1/0012", o_stage_valid[2], s_ctl(2)); end
      tick();
      checks++; if (o_stage_valid[2] !== 1'b1 || s_ctl(2) !== 16'h13) begin errors++; $display("FAIL stall_drain2 got v=%b ctl=%h exp 1/0013", o_stage_valid[2], s_ctl(2)); end
      tick();
      checks++; if (o_stage_valid !== 3'b000) begin errors++; $display("FAIL stall_empty got %b exp 000", o_stage_valid); end
   endtask

   task automatic test_flush_beats_stall();
      i_valid = 1'b1; i_ctl = 16'h20; i_rd = 5'd6;
      tick();
      checks++; if (o_stage_valid[0] !== 1'b1 || s_ctl(0) !== 16'h20) begin errors++; $display("FAIL flush_pre got v=%b ctl=%h exp 1/0020", o_stage_valid[0], s_ctl(0)); end
      i_ctl = 16'h21; i_stall = 3'b001; i_flush = 3'b001;
      tick();
      checks++; if (o_stage_valid[0] !== 1'b0 || s_ctl(0) !== 16'h0 || s_rd(0) !== 5'd0) begin
         errors++; $display("FAIL flush_s0 got v=%b ctl=%h rd=%0d exp 0/0000/0", o_stage_valid[0], s_ctl(0), s_rd(0));
      end
      checks++; if (o_stage_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_s1_bubble got %b exp 0", o_stage_valid[1]); end
      i_stall = 3'b000; i_flush = 3'b000; i_valid = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_load_use();
      i_valid = 1'b1; i_ctl = 16'h0003; i_rd = 5'd5; i_rs1 = 5'd7; i_rs2 = 5'd5;
      tick();
      checks++; if (o_load_use !== 1'b1) begin errors++; $display("FAIL lu_hit got %b exp 1", o_load_use); end
      checks++; if (o_rs2_busy !== 3'b001) begin errors++; $display("FAIL lu_rs2_busy got %b exp 001", o_rs2_busy); end
      checks++; if (o_rs1_busy !== 3'b000) begin errors++; $display("FAIL lu_rs1_busy got %b exp 000", o_rs1_busy); end
      i_rd = 5'd0; i_rs1 = 5'd0; i_rs2 = 5'd0;
      tick();
      checks++; if (o_load_use !== 1'b0) begin errors++; $display("FAIL lu_x0 got %b exp 0", o_load_use); end
      checks++; if (o_rs1_busy !== 3'b000 || o_rs2_busy !== 3'b000) begin errors++; $display("FAIL lu_x0_busy got %b/%b exp 000/000", o_rs1_busy, o_rs2_busy); end
      i_rs2 = 5'd5;
      #1;
      checks++; if (o_rs2_busy !== 3'b010 || o_load_use !== 1'b0) begin errors++; $display("FAIL lu_s1_busy got %b lu=%b exp 010 lu=0", o_rs2_busy, o_load_use); end
      i_valid = 1'b0; i_rs2 = 5'd0;
      tick(); tick(); tick();
   endtask

   task automatic test_async_reset();
      i_valid = 1'b1; i_ctl = 16'h0001; i_rd = 5'd3;
      tick(); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (o_stage_valid !== 3'b000) begin errors++; $display("FAIL areset_valid got %b exp 000", o_stage_valid); end
      checks++; if (o_retired_cnt !== 32'd0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", o_retired_cnt); end
      checks++; if (o_stage_ctl !== 48'h0) begin errors++; $display("FAIL areset_ctl got %h exp 0", o_stage_ctl); end
      i_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      d4_valid = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 18) begin
            checks++; if (d4_retired_cnt !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d exp 15", d4_retired_cnt); end
         end
         if (e == 19) begin
            checks++; if (d4_retired_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", d4_retired_cnt); end
         end
         if (e == 20) begin
            checks++; if (d4_retired_cnt !== 4'd1) begin errors++; $display("FAIL wrap_one got %0d exp 1", d4_retired_cnt); end
         end
      end
      d4_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stream();
      test_stall();
      test_flush_beats_stall();
      test_load_use();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
